clk_divide_bank: RTL
====================

CLK_DIVIDE_BANK -- requirements
Module: clk_divide_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, meaning divisor and counter width per channel (2..32).
REQ-003 SHALL have port clk_in  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  NUM_CH  meaning per-channel run enable, level-sensitive.
REQ-006 SHALL have port divisor  input  NUM_CH*CNT_W  meaning per-channel divisor D; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-007 SHALL have port load  input  NUM_CH  meaning per-channel one-cycle strobe capturing that channel's divisor slice.
REQ-008 SHALL have port sync  input  1  meaning one-cycle strobe restarting all running channels in phase.
REQ-009 SHALL have port clk_out  output  NUM_CH  meaning registered divided clock per channel.
REQ-010 SHALL have port tick  output  NUM_CH  meaning registered one-cycle pulse at the start of each output period.
REQ-011 SHALL have port pending  output  NUM_CH  meaning a loaded divisor is waiting for the period boundary.

Function
REQ-012 Each channel SHALL hold an active divisor act_d, a shadow divisor pend_d with flag pending, a counter cnt (CNT_W bits) and a running flag.
REQ-013 load while running=0 SHALL write act_d directly at that edge; pending stays 0.
REQ-014 load while running=1 SHALL write pend_d and set pending; a later load before the boundary overwrites pend_d.
REQ-015 Boundary (running, cnt==act_d-1): cnt->0; if pending, act_d<=pend_d and pending->0; load in the same cycle SHALL be adopted directly at this boundary.
REQ-016 Edge sampling enable=1 with running=0 SHALL set running=1, cnt=0, clk_out=1, tick=1 (for act_d>=2).
REQ-017 While running, each edge SHALL advance cnt (wrap per REQ-015) and set clk_out = (next cnt < ceil(act_d/2)), tick = (next cnt == 0).
REQ-018 Output period SHALL be exactly act_d clk_in cycles: clk_out high ceil(D/2), low floor(D/2); odd D gives the extra cycle to high phase.
REQ-019 act_d==0 SHALL hold the channel stopped: clk_out=0, tick=0, cnt=0, running ignored.
REQ-020 act_d==1 SHALL give clk_out=1 constantly and tick=1 every cycle while running.
REQ-021 enable sampled 0 SHALL stop the channel at that edge: running=0, cnt=0, clk_out=0, tick=0; pending and pend_d preserved and applied on next load or restart via REQ-022.
REQ-022 On restart (REQ-016) a set pending SHALL be applied to act_d before counting, clearing pending.
REQ-023 sync SHALL force cnt=0, clk_out=1, tick=1 on every running channel at that edge, applying pending divisors; stopped channels unaffected.
REQ-024 Simultaneous sync and enable rise on a channel SHALL behave as REQ-016 (identical result).
REQ-025 Channels SHALL be fully independent except for sync and the shared clock/reset.
REQ-026 Divisor arithmetic SHALL be unsigned CNT_W-bit; ceil(D/2) computed as (D>>1)+D[0] without overflow.

Reset
REQ-027 reset low SHALL asynchronously clear clk_out, tick, pending, running, cnt, act_d, pend_d to 0 for all channels.
REQ-028 Release SHALL be synchronised to clk_in edges; first active edge after release behaves as a normal cycle with act_d=0 (channels idle until loaded).

Structure
REQ-029 Package clk_divide_pkg SHALL hold CNT_W default, NUM_CH default and a half-period helper function.
REQ-030 Per-channel logic SHALL be a sub-module clk_divide_chan, instantiated NUM_CH times via generate.
REQ-031 All outputs SHALL be driven directly from flops; no combinational path from inputs to outputs.

Verification
REQ-032 Load D=6 ch0, enable -> clk_out 3 high/3 low, tick every 6 cycles, first tick at enable edge.
REQ-033 Load D=5, enable -> clk_out 3 high/2 low, period 5; D=1 -> clk_out steady 1, tick every cycle.
REQ-034 Running D=4, load D=10 mid-period -> pending=1, current period completes at 4, next period 10, pending clears at boundary.
REQ-035 ch0 D=4, ch1 D=6 running out of phase, pulse sync -> both tick same cycle, periods 4 and 6 continue from there.
REQ-036 Assert reset low mid-high-phase (asynchronous, between edges) -> all outputs 0 immediately; after release, outputs stay 0 until load+enable.
REQ-037 Drop enable mid-period on D=8 -> outputs 0 next edge; re-enable -> clean restart, full 4-high phase, tick at restart edge.

Source files
------------

// File: rtl/clk_divide_pkg.sv
// clk_divide_pkg: shared defaults and half-period helper for the divider bank
package clk_divide_pkg;
  localparam int CNT_W_DEF  = 32;
  localparam int NUM_CH_DEF = 4;
  function automatic logic [31:0] half_up(input logic [31:0] d);
    return (d >> 1) + {31'd0, d[0]};
  endfunction
endpackage

// File: rtl/clk_divide_chan.sv
// clk_divide_chan: one divide-by-D channel with shadowed divisor reload
module clk_divide_chan
  import clk_divide_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             sync,
  input  logic [CNT_W-1:0] divisor,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);
  logic [CNT_W-1:0] act_d, pend_d, cnt, cnt_inc, new_d, half;
  logic running, wrap, apply;
  always_comb begin
    cnt_inc = cnt + CNT_W'(1);
    half    = CNT_W'(half_up(32'(act_d)));
    wrap    = running && (cnt_inc == act_d);
    apply   = enable && (!running || sync || wrap);
    new_d   = load ? divisor : pending ? pend_d : act_d;
  end
  // apply covers restart, sync and period boundary: each begins a fresh period
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      act_d   <= '0;
      pend_d  <= '0;
      pending <= 1'b0;
      cnt     <= '0;
      running <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (apply) begin
      act_d   <= new_d;
      pending <= 1'b0;
      cnt     <= '0;
      running <= |new_d;
      clk_out <= |new_d;
      tick    <= |new_d;
    end else if (enable) begin
      cnt     <= cnt_inc;
      clk_out <= cnt_inc < half;
      tick    <= 1'b0;
      if (load) begin
        pend_d  <= divisor;
        pending <= 1'b1;
      end
    end else begin
      running <= 1'b0;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      if (load && running) begin
        pend_d  <= divisor;
        pending <= 1'b1;
      end else if (load) begin
        act_d   <= divisor;
        pending <= 1'b0;
      end
    end
endmodule

// File: rtl/clk_divide_bank.sv
// clk_divide_bank: bank of independent programmable clock dividers with common sync
module clk_divide_bank
  import clk_divide_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*CNT_W-1:0] divisor,
  input  logic [NUM_CH-1:0]       load,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_divide_chan #(.CNT_W(CNT_W)) u_chan (
      .clk_in  (clk_in),
      .reset   (reset),
      .enable  (enable[i]),
      .load    (load[i]),
      .sync    (sync),
      .divisor (divisor[i*CNT_W +: CNT_W]),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end
endmodule
